// File: rtl/bt_pkg.sv
// bt_pkg: opcodes, FSM encodings and the volume-expansion rule shared by bt_cmd_ctrl and uart_rx.
package bt_pkg;

    localparam logic [7:0] OP_PAUSE    = 8'h01;
    localparam logic [7:0] OP_NEXT     = 8'h02;
    localparam logic [7:0] OP_PREV     = 8'h03;
    localparam logic [7:0] OP_VOL_UP   = 8'h04;
    localparam logic [7:0] OP_VOL_DN   = 8'h05;
    localparam logic [7:0] OP_MUTE     = 8'h06;
    localparam logic [7:0] OP_LOOP     = 8'h07;
    localparam logic [7:0] OP_SET_SONG = 8'h08;
    localparam logic [7:0] OP_SET_VOL  = 8'h09;

    typedef enum logic {IDLE, WAIT_ARG} cmd_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Argument byte fills the top 8 bits; the low bits replicate arg[0] so 0xFF maps to full scale.
    function automatic logic [31:0] vol_expand(input logic [7:0] arg, input int vol_w);
        return {arg, {24{arg[0]}}} >> (32 - vol_w);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; samples each bit mid-period and pulses rx_done for one cycle per valid byte.
module uart_rx
    import bt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_done,
    output logic [7:0] rx_data
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB) + 1;

    rx_state_t     state, state_n;
    logic [1:0]    sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    data_n;
    logic          done_n;
    logic          rxs;

    assign rxs = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            state   <= RX_IDLE;
            cnt     <= '0;
            idx     <= '0;
            rx_data <= '0;
            rx_done <= 1'b0;
        end else begin
            sync    <= {sync[0], rx};
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            rx_data <= data_n;
            rx_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        data_n  = rx_data;
        done_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = RX_START;
            end
            RX_START: if (cnt == CW'(CPB / 2 - 1)) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == CW'(CPB - 1)) begin
                cnt_n  = '0;
                data_n = {rxs, rx_data[7:1]};
                idx_n  = idx + 1'b1;
                if (idx == 3'd7) state_n = RX_STOP;
            end
            RX_STOP: if (cnt == CW'(CPB - 1)) begin
                cnt_n   = '0;
                state_n = RX_IDLE;
                done_n  = rxs;
            end
        endcase
    end

endmodule

// File: rtl/bt_cmd_ctrl.sv
// bt_cmd_ctrl: decodes UART command bytes into player state (track, volume, pause/mute/loop).
module bt_cmd_ctrl
    import bt_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int NUM_SONGS   = 4,
    parameter int VOL_W       = 16,
    parameter int VOL_STEP    = 4079,
    parameter int ARG_TIMEOUT = 1_000_000,
    localparam int SONG_W     = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              i_finish,
    output logic [VOL_W-1:0]  o_vol,
    output logic [SONG_W-1:0] o_song,
    output logic              o_pause,
    output logic              o_mute,
    output logic              o_loop,
    output logic              o_song_change,
    output logic              o_cmd_err
);

    localparam int TW = $clog2(ARG_TIMEOUT + 1);
    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    cmd_state_t        state, state_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              arg_vol, arg_vol_n;
    logic [VOL_W-1:0]  vol, vol_n;
    logic [SONG_W-1:0] song_n, song_nxt;
    logic              pause_n, mute_n, loop_n, chg_n, err_n, song_cmd;
    logic [VOL_W:0]    vol_up;
    logic              rx_done;
    logic [7:0]        rx_data;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_done (rx_done),
        .rx_data (rx_data)
    );

    assign o_vol    = o_mute ? '0 : vol;
    assign vol_up   = {1'b0, vol} + (VOL_W + 1)'(VOL_STEP);
    assign song_nxt = (o_song == SONG_W'(NUM_SONGS - 1)) ? '0 : o_song + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            arg_vol       <= 1'b0;
            vol           <= VOL_MAX;
            o_song        <= '0;
            o_pause       <= 1'b0;
            o_mute        <= 1'b0;
            o_loop        <= 1'b0;
            o_song_change <= 1'b0;
            o_cmd_err     <= 1'b0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            arg_vol       <= arg_vol_n;
            vol           <= vol_n;
            o_song        <= song_n;
            o_pause       <= pause_n;
            o_mute        <= mute_n;
            o_loop        <= loop_n;
            o_song_change <= chg_n;
            o_cmd_err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        tcnt_n    = '0;
        arg_vol_n = arg_vol;
        vol_n     = vol;
        song_n    = o_song;
        pause_n   = o_pause;
        mute_n    = o_mute;
        loop_n    = o_loop;
        chg_n     = 1'b0;
        err_n     = 1'b0;
        song_cmd  = 1'b0;
        if (state == WAIT_ARG) begin
            tcnt_n = tcnt + 1'b1;
            if (rx_done) begin
                state_n = IDLE;
                if (arg_vol) begin
                    vol_n  = VOL_W'(vol_expand(rx_data, VOL_W));
                    mute_n = 1'b0;
                end else if ({24'd0, rx_data} < 32'(NUM_SONGS)) begin
                    song_n   = SONG_W'(rx_data);
                    song_cmd = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
            end else if (tcnt == TW'(ARG_TIMEOUT)) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end
        end else if (rx_done) begin
            case (rx_data)
                OP_PAUSE:  pause_n = !o_pause;
                OP_NEXT: begin
                    song_n   = song_nxt;
                    song_cmd = 1'b1;
                end
                OP_PREV: begin
                    song_n   = (o_song == '0) ? SONG_W'(NUM_SONGS - 1) : o_song - 1'b1;
                    song_cmd = 1'b1;
                end
                OP_VOL_UP: begin
                    vol_n  = vol_up[VOL_W] ? VOL_MAX : vol_up[VOL_W-1:0];
                    mute_n = 1'b0;
                end
                OP_VOL_DN: begin
                    vol_n  = (vol < VOL_W'(VOL_STEP)) ? '0 : vol - VOL_W'(VOL_STEP);
                    mute_n = 1'b0;
                end
                OP_MUTE:   mute_n = !o_mute;
                OP_LOOP:   loop_n = !o_loop;
                OP_SET_SONG, OP_SET_VOL: begin
                    state_n   = WAIT_ARG;
                    arg_vol_n = (rx_data == OP_SET_VOL);
                end
                default:   err_n = 1'b1;
            endcase
        end
        // A track-changing command overrides a coincident finish.
        if (song_cmd) begin
            chg_n   = 1'b1;
            pause_n = 1'b0;
        end else if (i_finish && !o_pause) begin
            chg_n = 1'b1;
            if (!o_loop) song_n = song_nxt;
        end
    end

endmodule
